// File: rtl/data_memory_arbiter.sv
// Arbitrates the single data-memory port between instruction fetch and the load/store unit.
// Optional round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
module data_memory_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_req_we,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic [DATA_W-1:0] ls_req_wdata,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  state_t state;
  state_t state_nxt;
  logic   owner;
  logic   pick_ls;
  logic   grant_if;
  logic   grant_ls;
  logic   can_grant;

  assign can_grant = !rst && (state == IDLE);

`ifdef MEM_ARB_RR_EN
  logic last_grant;

  // On a contest the port that did not win last time goes first.
  assign pick_ls = ls_req_valid && (!if_req_valid || (last_grant == OWN_IF));

  always_ff @(posedge clk) begin
    if (rst)           last_grant <= OWN_IF;
    else if (grant_ls) last_grant <= OWN_LS;
    else if (grant_if) last_grant <= OWN_IF;
  end
`else
  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_if;
  logic             guard_on;

  assign guard_on = (STARVE_LIMIT != 0);
  assign force_if = guard_on && if_req_valid && (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign pick_ls  = ls_req_valid && !force_if;

  // Counts LSU wins over a waiting fetch; saturates so fetch gets forced through.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_ls && if_req_valid && guard_on &&
                 (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

  assign grant_ls = can_grant && pick_ls;
  assign grant_if = can_grant && if_req_valid && !pick_ls;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Read owner is latched at grant so the response is routed back correctly.
  always_ff @(posedge clk) begin
    if (rst)                          owner <= OWN_IF;
    else if (grant_if)                owner <= OWN_IF;
    else if (grant_ls && !ls_req_we)  owner <= OWN_LS;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_if || (grant_ls && !ls_req_we)) state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic; everything idles to zero while reset is asserted.
  always_comb begin
    if_req_ready = 1'b0;
    ls_req_ready = 1'b0;
    if_rsp_valid = 1'b0;
    ls_rsp_valid = 1'b0;
    if_rsp_data  = '0;
    ls_rsp_data  = '0;
    mem_addr     = '0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (grant_ls) begin
            ls_req_ready = 1'b1;
            mem_addr     = ls_req_addr;
            if (ls_req_we) begin
              mem_we    = 1'b1;
              mem_wdata = ls_req_wdata;
            end else begin
              mem_re = 1'b1;
            end
          end else if (grant_if) begin
            if_req_ready = 1'b1;
            mem_addr     = if_req_addr;
            mem_re       = 1'b1;
          end
        end
        RD_WAIT: begin
          if (owner == OWN_LS) begin
            ls_rsp_valid = 1'b1;
            ls_rsp_data  = mem_rdata;
          end else begin
            if_rsp_valid = 1'b1;
            if_rsp_data  = mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Randomized bench for data_memory_arbiter against a transaction-level reference model.
module tb_data_memory_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SL = 4;
  localparam int NCYC = 2000;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_valid, if_req_ready, if_rsp_valid;
  logic [AW-1:0] if_req_addr;
  logic [DW-1:0] if_rsp_data;
  logic          ls_req_valid, ls_req_ready, ls_req_we, ls_rsp_valid;
  logic [AW-1:0] ls_req_addr;
  logic [DW-1:0] ls_req_wdata, ls_rsp_data;
  logic [AW-1:0] mem_addr;
  logic          mem_re, mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  data_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_we(ls_req_we),
    .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous RAM with one-cycle read latency, 16 words deep.
  bit [DW-1:0] ram [16];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[3:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr[3:0]];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: what the memory should hold and which read is outstanding.
  bit [DW-1:0] shadow [16];
  bit          m_busy;
  bit          m_owner_ls;
  bit [DW-1:0] m_rd_data;
  int          m_lsu_wins;
  bit          m_last_ls;

  bit          e_if_rdy, e_ls_rdy, e_re, e_we, e_if_rv, e_ls_rv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  int          phase;

  task automatic new_if_req();
    bit go;
    go = (phase == 1 || phase == 2) ? 1'b1 : ($urandom_range(0, 9) < 6);
    if_req_valid = go;
    if_req_addr  = AW'($urandom_range(0, 15));
  endtask

  task automatic new_ls_req();
    bit go;
    go = (phase == 1 || phase == 2) ? 1'b1 : ($urandom_range(0, 9) < 6);
    ls_req_valid = go;
    ls_req_we    = (phase == 1) ? 1'b1 : (phase == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    ls_req_addr  = AW'($urandom_range(0, 15));
    ls_req_wdata = DW'($urandom);
  endtask

  initial begin
    bit win_ls, win_if;
    rst          = 1'b1;
    phase        = 0;
    if_req_valid = 1'b1;
    if_req_addr  = AW'(32'h10);
    ls_req_valid = 1'b1;
    ls_req_we    = 1'b0;
    ls_req_addr  = AW'(32'h20);
    ls_req_wdata = DW'(32'h1);
    m_busy = 1'b0; m_owner_ls = 1'b0; m_lsu_wins = 0; m_last_ls = 1'b0; m_rd_data = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      win_ls = 1'b0;
      win_if = 1'b0;
      e_if_rdy = 0; e_ls_rdy = 0; e_re = 0; e_we = 0; e_if_rv = 0; e_ls_rv = 0;
      e_addr = '0; e_wdata = '0;
      if (!rst && !m_busy) begin
`ifdef MEM_ARB_RR_EN
        if (ls_req_valid && if_req_valid) win_ls = !m_last_ls;
        else                              win_ls = ls_req_valid;
`else
        // Fetch is forced through after SL LSU wins in a row while it waited.
        if (ls_req_valid && !(if_req_valid && SL != 0 && m_lsu_wins >= int'(SL))) win_ls = 1'b1;
`endif
        win_if = if_req_valid && !win_ls;
        if (win_ls) begin
          e_ls_rdy = 1; e_addr = ls_req_addr;
          if (ls_req_we) begin e_we = 1; e_wdata = ls_req_wdata; end
          else e_re = 1;
        end else if (win_if) begin
          e_if_rdy = 1; e_addr = if_req_addr; e_re = 1;
        end
      end else if (!rst && m_busy) begin
        e_ls_rv = m_owner_ls;
        e_if_rv = !m_owner_ls;
      end

      check("if_req_ready", 64'(if_req_ready), 64'(e_if_rdy));
      check("ls_req_ready", 64'(ls_req_ready), 64'(e_ls_rdy));
      check("mem_re",       64'(mem_re),       64'(e_re));
      check("mem_we",       64'(mem_we),       64'(e_we));
      check("mem_addr",     64'(mem_addr),     64'(e_addr));
      check("mem_wdata",    64'(mem_wdata),    64'(e_wdata));
      check("if_rsp_valid", 64'(if_rsp_valid), 64'(e_if_rv));
      check("ls_rsp_valid", 64'(ls_rsp_valid), 64'(e_ls_rv));
      if (e_if_rv) check("if_rsp_data", 64'(if_rsp_data), 64'(m_rd_data));
      if (e_ls_rv) check("ls_rsp_data", 64'(ls_rsp_data), 64'(m_rd_data));
      if (rst) begin
        check("if_rsp_data_rst", 64'(if_rsp_data), 64'd0);
        check("ls_rsp_data_rst", 64'(ls_rsp_data), 64'd0);
      end

      // Advance the model by one cycle.
      if (rst) begin
        m_busy = 1'b0; m_lsu_wins = 0; m_last_ls = 1'b0;
      end else if (m_busy) begin
        m_busy = 1'b0;
      end else if (win_ls) begin
        m_last_ls = 1'b1;
        if (if_req_valid && m_lsu_wins < int'(SL)) m_lsu_wins++;
        if (ls_req_we) shadow[ls_req_addr[3:0]] = ls_req_wdata;
        else begin
          m_busy = 1'b1; m_owner_ls = 1'b1; m_rd_data = shadow[ls_req_addr[3:0]];
        end
      end else if (win_if) begin
        m_last_ls = 1'b0; m_lsu_wins = 0;
        m_busy = 1'b1; m_owner_ls = 1'b0; m_rd_data = shadow[if_req_addr[3:0]];
      end

      @(posedge clk);
      #1;
      phase = (cyc < 400) ? 0 : (cyc < 600) ? 1 : (cyc < 800) ? 2 : 3;
      if (cyc < 1)        rst = 1'b1;
      else if (phase == 3) rst = ($urandom_range(0, 49) == 0);
      else                 rst = 1'b0;
      if (win_if || !if_req_valid) new_if_req();
      if (win_ls || !ls_req_valid) new_ls_req();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
